// File: rtl/bsg_wormhole_router_output_alloc.sv
// ---------------------------------------------------------------------------
// bsg_wormhole_router_output_alloc
//
// Per-output-port wormhole allocator. Picks one requesting input by
// round-robin, locks the output to that input until the packet's last flit
// has moved, and drives the crossbar select and the input-FIFO dequeue
// strobes.
//
// Ports:
//   clk_i      : clock
//   reset_n_i  : asynchronous active-low reset
//   req_i      : per-input header request for this output direction
//   len_i      : per-input header length (body flits), input i at
//                [i*len_width_p +: len_width_p]
//   valid_i    : per-input FIFO head valid
//   ready_i    : downstream link accepts a flit this cycle
//   valid_o    : flit presented to the output link
//   yumi_o     : one-hot dequeue strobe to the granted input FIFO
//   sel_o      : one-hot crossbar select, zero when idle
//   busy_o     : output locked to a packet
// ---------------------------------------------------------------------------
module bsg_wormhole_router_output_alloc #(
    parameter int inputs_p    = 5,
    parameter int len_width_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [inputs_p-1:0]             req_i,
    input  logic [inputs_p*len_width_p-1:0] len_i,
    input  logic [inputs_p-1:0]             valid_i,
    input  logic                            ready_i,
    output logic                            valid_o,
    output logic [inputs_p-1:0]             yumi_o,
    output logic [inputs_p-1:0]             sel_o,
    output logic                            busy_o
);

    localparam int IDX_W = (inputs_p > 1) ? $clog2(inputs_p) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                  state_r;
    logic [inputs_p-1:0]     sel_r;
    logic [inputs_p-1:0]     last_r;
    logic [len_width_p:0]    cnt_r;

    logic [IDX_W-1:0]        last_idx_s;
    logic [IDX_W-1:0]        grant_idx_s;
    logic [inputs_p-1:0]     grant_s;
    logic [len_width_p-1:0]  len_sel_s;
    logic [len_width_p:0]    cnt_load_s;
    logic                    head_valid_s;
    logic                    xfer_s;

    // Convert the one-hot last-winner register into an index.
    always_comb begin
        last_idx_s = '0;
        for (int i = 0; i < inputs_p; i++) begin
            if (last_r[i]) begin
                last_idx_s = IDX_W'(i);
            end else begin
                last_idx_s = last_idx_s;
            end
        end
    end

    // Round-robin pick: first set request scanning upward from last winner + 1.
    // Scanning offsets 1..inputs_p means the last winner is checked last.
    always_comb begin
        int  idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        grant_s     = '0;
        grant_idx_s = '0;
        for (int k = 1; k <= inputs_p; k++) begin
            idx = int'(last_idx_s) + k;
            if (idx >= inputs_p) begin
                idx = idx - inputs_p;
            end else begin
                idx = idx;
            end
            if (!found && req_i[idx]) begin
                grant_s[idx] = 1'b1;
                grant_idx_s  = IDX_W'(idx);
                found        = 1'b1;
            end else begin
                found = found;
            end
        end
    end

    // Length of the winning header; the extra bit keeps len+1 from wrapping.
    assign len_sel_s  = len_i[grant_idx_s*len_width_p +: len_width_p];
    assign cnt_load_s = {1'b0, len_sel_s} + (len_width_p+1)'(1);

    assign head_valid_s = |(sel_r & valid_i);
    assign xfer_s       = (state_r == BUSY) && head_valid_s && ready_i;

    // Link-side outputs are combinational from the lock, valid_i and ready_i only.
    always_comb begin
        if (state_r == BUSY) begin
            valid_o = head_valid_s;
        end else begin
            valid_o = 1'b0;
        end
        if (xfer_s) begin
            yumi_o = sel_r;
        end else begin
            yumi_o = '0;
        end
    end

    assign sel_o  = sel_r;
    assign busy_o = (state_r == BUSY);

    // Allocation state machine: arbitrate in IDLE, count flits out in BUSY.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            sel_r   <= '0;
            cnt_r   <= '0;
            last_r  <= {1'b1, {(inputs_p-1){1'b0}}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req_i) begin
                        sel_r   <= grant_s;
                        last_r  <= grant_s;
                        cnt_r   <= cnt_load_s;
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (xfer_s) begin
                        cnt_r <= cnt_r - (len_width_p+1)'(1);
                        if (cnt_r == (len_width_p+1)'(1)) begin
                            state_r <= IDLE;
                            sel_r   <= '0;
                        end else begin
                            state_r <= BUSY;
                        end
                    end else begin
                        state_r <= BUSY;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sel_r   <= '0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_wormhole_router_output_alloc.sv
// ---------------------------------------------------------------------------
// Directed, table-driven bench for bsg_wormhole_router_output_alloc.
// Each record holds the inputs for one clock cycle and the outputs expected
// during that cycle (before the next rising edge). A record with rst_n = 0
// asserts the asynchronous reset for that cycle.
// ---------------------------------------------------------------------------
module tb_bsg_wormhole_router_output_alloc;

    logic        clk;
    logic        rst_n;
    logic [4:0]  req;
    logic [19:0] len;
    logic [4:0]  valid;
    logic        ready;
    logic        valid_o;
    logic [4:0]  yumi_o;
    logic [4:0]  sel_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          rst_n;
        logic [4:0]  req;
        logic [19:0] len;
        logic [4:0]  valid;
        bit          ready;
        bit          exp_valid;
        logic [4:0]  exp_yumi;
        logic [4:0]  exp_sel;
        bit          exp_busy;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    bsg_wormhole_router_output_alloc #(
        .inputs_p    (5),
        .len_width_p (4)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .req_i     (req),
        .len_i     (len),
        .valid_i   (valid),
        .ready_i   (ready),
        .valid_o   (valid_o),
        .yumi_o    (yumi_o),
        .sel_o     (sel_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] lenf(int idx, int l);
        logic [19:0] r;
        r = 20'd0;
        r[idx*4 +: 4] = 4'(l);
        return r;
    endfunction

    function automatic void add(string tag, bit rs, logic [4:0] rq, logic [19:0] ln,
                                logic [4:0] vl, bit rd, bit ev, logic [4:0] ey,
                                logic [4:0] es, bit eb);
        vec_t v;
        v.tag = tag; v.rst_n = rs; v.req = rq; v.len = ln; v.valid = vl; v.ready = rd;
        v.exp_valid = ev; v.exp_yumi = ey; v.exp_sel = es; v.exp_busy = eb;
        vecs.push_back(v);
    endfunction

    // Reset asserted: everything must be zero at once.
    function automatic void add_reset(string tag);
        add(tag, 1'b0, 5'd0, 20'd0, 5'b11111, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    endfunction

    // IDLE cycle (arbitration happens at the closing edge): outputs all zero.
    function automatic void add_idle(string tag, logic [4:0] rq, logic [19:0] ln);
        add(tag, 1'b1, rq, ln, 5'b11111, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    endfunction

    // BUSY cycle with a transfer from the locked input.
    function automatic void add_xfer(string tag, logic [4:0] rq, logic [19:0] ln, logic [4:0] s);
        add(tag, 1'b1, rq, ln, 5'b11111, 1'b1, 1'b1, s, s, 1'b1);
    endfunction

    task automatic cmp1(string tag, int n, string what, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] %s got=%b exp=%b", tag, n, what, got, exp);
        end
    endtask

    task automatic cmp5(string tag, int n, string what, logic [4:0] got, logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] %s got=%b exp=%b", tag, n, what, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 5'd0;
        len   = 20'd0;
        valid = 5'd0;
        ready = 1'b0;

        // Single packet, input 0, two body flits.
        add_reset("single");
        add_idle("single", 5'b00001, lenf(0, 2));
        for (int i = 0; i < 3; i++) add_xfer("single", 5'd0, 20'd0, 5'b00001);
        add_idle("single", 5'd0, 20'd0);

        // Everybody requests, header-only packets: 0,1,2,3,4,0 with a bubble each.
        add_reset("rr");
        for (int g = 0; g < 6; g++) begin
            add_idle("rr", 5'b11111, 20'd0);
            add_xfer("rr", 5'b11111, 20'd0, 5'(1 << (g % 5)));
        end

        // Input 2, len 3, ready toggling: 4 transfers, stalls in between.
        add_reset("stall");
        add_idle("stall", 5'b00100, lenf(2, 3));
        for (int c = 0; c < 7; c++) begin
            if (c % 2 == 0) add("stall", 1'b1, 5'd0, 20'd0, 5'b11111, 1'b1, 1'b1, 5'b00100, 5'b00100, 1'b1);
            else            add("stall", 1'b1, 5'd0, 20'd0, 5'b11111, 1'b0, 1'b1, 5'b00000, 5'b00100, 1'b1);
        end
        add_idle("stall", 5'd0, 20'd0);

        // Input 1 locked, input 3 requests mid-packet; also a valid_i stall.
        add_reset("lock");
        add_idle("lock", 5'b00010, lenf(1, 2));
        add_xfer("lock", 5'd0, 20'd0, 5'b00010);
        add("lock", 1'b1, 5'b01000, lenf(3, 1), 5'b11101, 1'b1, 1'b0, 5'b00000, 5'b00010, 1'b1);
        add_xfer("lock", 5'b01000, lenf(3, 1), 5'b00010);
        add_xfer("lock", 5'b01000, lenf(3, 1), 5'b00010);
        add_idle("lock", 5'b01000, lenf(3, 1));
        add_xfer("lock", 5'd0, 20'd0, 5'b01000);
        add_xfer("lock", 5'd0, 20'd0, 5'b01000);
        add_idle("lock", 5'd0, 20'd0);

        // Maximum length: 16 transfers, no wrap.
        add_reset("max");
        add_idle("max", 5'b00001, lenf(0, 15));
        for (int i = 0; i < 16; i++) add_xfer("max", 5'd0, 20'd0, 5'b00001);
        add_idle("max", 5'd0, 20'd0);
        add_idle("max", 5'd0, 20'd0);

        // Reset mid-packet (cnt 5), then priority back at input 0.
        add_reset("midrst");
        add_idle("midrst", 5'b00100, lenf(2, 6));
        add_xfer("midrst", 5'd0, 20'd0, 5'b00100);
        add_xfer("midrst", 5'd0, 20'd0, 5'b00100);
        add_reset("midrst");
        add_idle("midrst", 5'b10001, 20'd0);
        add_xfer("midrst", 5'b10001, 20'd0, 5'b00001);
        add_idle("midrst", 5'b10001, 20'd0);
        add_xfer("midrst", 5'd0, 20'd0, 5'b10000);
        add_idle("midrst", 5'd0, 20'd0);

        foreach (vecs[n]) begin
            @(negedge clk);
            rst_n = vecs[n].rst_n;
            req   = vecs[n].req;
            len   = vecs[n].len;
            valid = vecs[n].valid;
            ready = vecs[n].ready;
            #1;
            cmp1(vecs[n].tag, n, "valid_o", valid_o, vecs[n].exp_valid);
            cmp5(vecs[n].tag, n, "yumi_o",  yumi_o,  vecs[n].exp_yumi);
            cmp5(vecs[n].tag, n, "sel_o",   sel_o,   vecs[n].exp_sel);
            cmp1(vecs[n].tag, n, "busy_o",  busy_o,  vecs[n].exp_busy);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
